// File: rtl/uart_tx_frame.sv
// UART transmit stage: one-entry holding register feeding a start/data/parity/stop
// serialiser with its own bit-rate divider; frames can run back-to-back.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          tick_q, tick_d;
  logic          tick_now, load, accept;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    tick_now    = (state_q != IDLE) && (cnt_q == CNT_MAX);
    accept      = tx_valid && !hold_full_q;
    cnt_d       = (state_q == IDLE || tick_now) ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE:
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      START:
        if (tick_now) begin
          state_d = DATA;
          idx_d   = 3'd7;
        end
      DATA:
        if (tick_now) begin
          if (idx_q == 3'd0) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      PARITY:
        if (tick_now) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      STOP:
        if (tick_now) begin
          if (stop_q == STOP_LAST) begin
            // Held byte goes straight into the next start bit, no idle cycle.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      stop_d      = 1'b0;
    end
    // accept needs an empty holder, load a full one, so they never collide
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Outputs are registered, so decode them from the next-state values.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[idx_d];
      PARITY:  tx_out_d = ^shift_d;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    tick_d = (state_d != IDLE) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd7;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_out_q    <= 1'b1;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_out_q    <= tx_out_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_out   = tx_out_q;
  assign tx_busy  = busy_q;
  assign bit_tick = tick_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations side by side, a frame-level queue
// model checked every cycle, plus literal line patterns for directed cases.
module tb_uart_tx_frame;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       r0, o0, b0, t0, r1, o1, b1, t1;

  int checks = 0;
  int errs   = 0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(r0), .tx_out(o0), .tx_busy(b0), .bit_tick(t0));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(r1), .tx_out(o1), .tx_busy(b1), .bit_tick(t1));

  always #5 clk = ~clk;

  // Model: each queue entry is {line, tick} for one future cycle of the frame.
  logic [1:0] mq [2][$];
  logic       mh [2];
  logic [7:0] mb [2];

  function automatic void push_frame(int k, logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
    if (k == 0) bits.push_back(^b);
    for (int s = 0; s < ((k == 0) ? 1 : 2); s++) bits.push_back(1'b1);
    foreach (bits[j])
      for (int c = 0; c < CPB; c++) mq[k].push_back({bits[j], c == CPB - 1});
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        mh[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic acc;
        acc = vld[k] && !mh[k];
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        if (mq[k].size() == 0 && mh[k]) begin
          push_frame(k, mb[k]);
          mh[k] = 1'b0;
        end
        if (acc) begin
          mh[k] = 1'b1;
          mb[k] = dat[k];
        end
      end
    end
  end

  // {tx_out, bit_tick, tx_busy, tx_ready} against the model every cycle
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [3:0] e, a;
      e = (mq[k].size() > 0) ? {mq[k][0], 1'b1, !mh[k]} : {3'b100, !mh[k]};
      a = (k == 0) ? {o0, t0, b0, r0} : {o1, t1, b1, r1};
      checks++;
      if (a !== e) begin
        errs++;
        $display("FAIL model%0d t=%0t: got %b want %b", k, $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] expand(logic [10:0] p);
    logic [43:0] w;
    for (int i = 0; i < 44; i++) w[i] = p[i / 4];
    return w;
  endfunction

  // Leaves the caller at accept edge + #1; tx_data is scrambled after the accept.
  task automatic send(input int k, input logic [7:0] b);
    @(posedge clk); #1;
    vld[k] = 1'b1; dat[k] = b;
    @(posedge clk); #1;
    vld[k] = 1'b0; dat[k] = 8'($urandom);
  endtask

  task automatic capture(input int k, output logic [43:0] w, output int nt);
    nt = 0;
    @(posedge clk);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      w[43 - i] = (k == 0) ? o0 : o1;
      nt += (k == 0) ? int'(t0) : int'(t1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((b0 || b1 || !r0 || !r1) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_timeout", n < 400, 1);
  endtask

  initial begin
    logic [43:0] w;
    int nt, n, busy_cnt;
    vld[0] = 0; vld[1] = 0; dat[0] = 0; dat[1] = 0;
    #12;
    chk("reset_state0", {o0, r0, b0, t0}, 4'b1100);
    chk("reset_state1", {o1, r1, b1, t1}, 4'b1100);
    @(negedge clk); reset = 1'b1;

    send(0, 8'hA5);
    capture(0, w, nt);
    chk("a5_line", w, expand(11'b0_10100101_0_1));
    chk("a5_ticks", nt, 11);
    @(negedge clk);
    chk("a5_idle_busy", b0, 0);

    send(0, 8'h07); capture(0, w, nt);
    chk("p07_line", w, expand(11'b0_00000111_1_1));
    send(0, 8'h00); capture(0, w, nt);
    chk("p00_line", w, expand(11'b0_00000000_0_1));

    send(1, 8'hFF); capture(1, w, nt);
    chk("ff_2stop_line", w, expand(11'b0_11111111_11));
    chk("ff_2stop_ticks", nt, 11);
    wait_idle();

    // back-to-back with tx_valid held high
    @(posedge clk); #1; vld[0] = 1; dat[0] = 8'h01;
    @(posedge clk); #1; dat[0] = 8'h80;
    chk("b2b_ready_low", r0, 0);
    @(posedge clk); #1;
    chk("b2b_ready_after_load", r0, 1);
    chk("b2b_start_bit", o0, 0);
    @(posedge clk); #1; dat[0] = 8'h3C;
    chk("b2b_second_accept", r0, 0);
    n = 0;
    while (!r0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("b2b_third_wait", n, 43);
    chk("b2b_no_gap", {o0, b0}, 2'b01);
    @(posedge clk); #1; vld[0] = 0;
    wait_idle();

    // reset during DATA bit 3 with a byte held
    send(0, 8'h5A);
    send(0, 8'hC3);
    chk("rst_hold_full", r0, 0);
    repeat (19) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_immediate", {o0, r0, b0}, 3'b110);
    @(negedge clk); @(negedge clk); reset = 1'b1;
    busy_cnt = 0;
    repeat (60) begin @(negedge clk); busy_cnt += int'(b0) + int'(!o0); end
    chk("rst_no_frame", busy_cnt, 0);

    // data toggling without valid sends nothing; the accept-edge value is sent
    busy_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1; dat[0] = 8'($urandom);
      @(negedge clk); busy_cnt += int'(b0);
    end
    chk("hyg_no_frame", busy_cnt, 0);
    send(0, 8'h96); capture(0, w, nt);
    chk("hyg_line", w, expand(11'b0_10010110_0_1));
    wait_idle();

    // random traffic on both configurations
    repeat (1500) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 3) == 0);
        dat[k] = 8'($urandom);
      end
    end
    vld[0] = 0; vld[1] = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
